data_mem_access: RTL and testbench

- Memory-access stage that consumes the Execute stage outputs.
- alu_result becomes the effective address; read_data2 becomes the store data.
- Runs LDUR/STUR-family loads and stores over a req/ack handshake to data memory, holding the core stalled via busy until the access completes.
- Handles byte-lane steering, load sign/zero extension, alignment checking and access faults.

---
 rtl/data_mem_access.sv | 206 ++++++++++++++++++++
 tb/tb_data_mem_access.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// Memory-access stage: runs one load/store per accepted start over a req/ack data bus.
// Latency: done 2 cycles after start with a zero-wait-state memory, 1 cycle on a fault.
// Backpressure: busy holds the core while in REQ/RESP; start is ignored unless IDLE.
//
// Optional feature macro: MEM_TIMEOUT_EN (bounded wait for mem_ack, faults after
// TIMEOUT_CYCLES cycles in REQ). Default build waits for ack forever.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, mem_read, mem_write    request strobe and operation select
//   size, sign_ext                access size (byte/half/word/double), load sign extension
//   address, store_data           effective byte address, right-justified store data
//   busy, done, fault, read_data  core-side status and extended load result
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata             bus request (doubleword aligned, lane steered)
//   mem_ack, mem_rdata            bus acknowledge and read data (same cycle)
module data_mem_access #(
    parameter int WORD           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [WORD-1:0] read_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [7:0]      mem_be,
    output logic [WORD-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata
);

    if (WORD != 64 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("data_mem_access: WORD must be 64 and TIMEOUT_CYCLES in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request fields latched at the accepted start
    logic            req_read;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_sext;
    logic [2:0]      req_off;
    logic            req_fault;

    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic            timeout_hit;
    logic [7:0]      be_calc;
    logic [WORD-1:0] lane_mask;
    logic [WORD-1:0] raw;
    logic [WORD-1:0] load_ext;

    assign accept  = (state == IDLE) && start;
    assign illegal = (mem_read == mem_write);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = address[0];
            2'b10:   misaligned = |address[1:0];
            2'b11:   misaligned = |address[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_calc = 8'h00;
        case (size)
            2'b00:   be_calc = 8'h01 << address[2:0];
            2'b01:   be_calc = 8'h03 << address[2:0];
            2'b10:   be_calc = 8'h0F << address[2:0];
            default: be_calc = 8'hFF;
        endcase
    end

    // Expand byte enables to a bit mask so unused lanes of mem_wdata are driven 0
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{be_calc[i]}};
        end
    end

    // Bring the addressed bytes down to bit 0, then extend by size
    assign raw = mem_rdata >> {req_off, 3'b000};

    always_comb begin
        load_ext = raw;
        case (req_size)
            2'b00:   load_ext = {{(WORD-8){req_sext & raw[7]}},   raw[7:0]};
            2'b01:   load_ext = {{(WORD-16){req_sext & raw[15]}}, raw[15:0]};
            2'b10:   load_ext = {{(WORD-32){req_sext & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Zero whenever outside REQ, so every REQ entry starts from 0
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
        end else if (state != REQ) begin
            tmo_cnt <= 8'd0;
        end else if (!mem_ack) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // An ack in the final cycle takes priority over the timeout
    assign timeout_hit = (state == REQ) && !mem_ack &&
                         (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (illegal || misaligned) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_size  <= 2'b00;
            req_sext  <= 1'b0;
            req_off   <= 3'd0;
            req_fault <= 1'b0;
            read_data <= '0;
            mem_addr  <= '0;
            mem_be    <= 8'h00;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                req_read  <= mem_read;
                req_write <= mem_write;
                req_size  <= size;
                req_sext  <= sign_ext;
                req_off   <= address[2:0];
                req_fault <= illegal || misaligned;
                mem_addr  <= {address[WORD-1:3], 3'b000};
                mem_be    <= be_calc;
                mem_wdata <= (store_data << {address[2:0], 3'b000}) & lane_mask;
            end
            if (state == REQ) begin
                if (mem_ack) begin
                    if (req_read) begin
                        read_data <= load_ext;
                    end
                end else if (timeout_hit) begin
                    req_fault <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == RESP);
    assign fault   = (state == RESP) && req_fault;
    assign mem_req = (state == REQ);
    assign mem_we  = (state == REQ) && req_write;

endmodule

// File: tb/tb_data_mem_access.sv
// Testbench for data_mem_access: scoreboard of expected completions checked at done.
// Latency: measured in clock cycles from the start cycle to the done cycle.
// Backpressure: bench memory inserts a programmable number of wait states before ack.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [63:0] address;
    logic [63:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [63:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    data_mem_access #(.WORD(64), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .read_data  (read_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        fault;
        logic [63:0] rd;
        int          lat;
        logic        req;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] addr;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] model_rd = '0;

    // Observations from the most recent access
    int          obs_lat;
    int          obs_reqcyc;
    bit          obs_to;
    logic        obs_req, obs_we, obs_fault;
    logic [7:0]  obs_be;
    logic [63:0] obs_wdata, obs_addr, obs_rd;

    function automatic logic [7:0] m_be(input logic [1:0] sz, input logic [2:0] off);
        int nb = 1 << sz;
        logic [7:0] v = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (b >= int'(off) && b < int'(off) + nb) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [1:0] sz,
                                            input logic [2:0] off);
        logic [7:0]  be = m_be(sz, off);
        logic [63:0] v  = '0;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) v[8*b +: 8] = d[8*(b - int'(off)) +: 8];
        end
        return v;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] d, input logic [1:0] sz,
                                           input logic [2:0] off, input logic sx);
        int nb = 1 << sz;
        logic [63:0] v = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < nb && int'(off) + b < 8) v[8*b +: 8] = d[8*(int'(off) + b) +: 8];
        end
        if (sx && sz != 2'b11 && v[8*nb-1]) begin
            for (int b = 0; b < 8; b++) begin
                if (b >= nb) v[8*b +: 8] = 8'hFF;
            end
        end
        return v;
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [63:0] addr, input logic [63:0] sdata);
        @(negedge clk);
        start      = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        size       = sz;
        sign_ext   = sx;
        address    = addr;
        store_data = sdata;
    endtask

    // Acts as the memory until done; records what the bus showed
    task automatic service(input int waits, input logic [63:0] rdata, input bit ack_en);
        obs_to = 1'b1; obs_req = 1'b0; obs_reqcyc = 0; obs_lat = 0;
        obs_be = '0; obs_wdata = '0; obs_addr = '0; obs_we = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                obs_lat = i; obs_fault = fault; obs_rd = read_data; obs_to = 1'b0;
                mem_ack = 1'b0;
                return;
            end
            if (mem_req) begin
                obs_req = 1'b1; obs_be = mem_be; obs_wdata = mem_wdata;
                obs_addr = mem_addr; obs_we = mem_we;
                mem_ack   = ack_en && (obs_reqcyc >= waits);
                mem_rdata = rdata;
                obs_reqcyc++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic pop_exp(input string name);
        tests++;
        if (obs_to || sb.size() == 0) begin
            fails++;
            $display("FAIL %s: done not seen within budget (timeout=%0d queued=%0d) required done", name, obs_to, sb.size());
            e = '{fault: 1'bx, rd: 'x, lat: -1, req: 1'bx, be: 'x, wdata: 'x, addr: 'x, we: 1'bx};
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
        sign_ext = 1'b0; address = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, fault, mem_req, mem_we} !== 5'b0 || mem_be !== 8'h00) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done/fault/req/we=%b be=%h required 00000 00", {busy, done, fault, mem_req, mem_we}, mem_be);
        end
        tests++;
        if (read_data !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: rd=%h addr=%h wdata=%h required all 0", read_data, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        // Reset during a stalled bus cycle
        issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h8000, '0);
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_setup: mem_req=%b required 1", mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({mem_req, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid: req/busy/done=%b required 000", {mem_req, busy, done});
        end
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({done, busy, read_data} !== {1'b0, 1'b0, 64'h0}) begin
                fails++;
                $display("FAIL reset_late_ack: done=%b busy=%b rd=%h required 0 0 0", done, busy, read_data);
            end
        end
        mem_ack = 1'b0;
        model_rd = '0;
    endtask

    task automatic test_load_double();
        logic [63:0] d = 64'h0123_4567_89AB_CDEF;
        issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h1000, '0);
        sb.push_back('{fault: 1'b0, rd: d, lat: 2, req: 1'b1, be: 8'hFF, wdata: '0, addr: 64'h1000, we: 1'b0});
        model_rd = d;
        service(0, d, 1'b1);
        pop_exp("ld_double");
        tests++;
        if (obs_lat != e.lat || obs_fault !== e.fault || obs_rd !== e.rd) begin
            fails++;
            $display("FAIL ld_double: lat=%0d fault=%b rd=%h required %0d %b %h", obs_lat, obs_fault, obs_rd, e.lat, e.fault, e.rd);
        end
        tests++;
        if (obs_addr !== e.addr || obs_be !== e.be || obs_we !== e.we) begin
            fails++;
            $display("FAIL ld_double_bus: addr=%h be=%h we=%b required %h %h %b", obs_addr, obs_be, obs_we, e.addr, e.be, e.we);
        end
    endtask

    task automatic test_store_byte();
        issue(1'b0, 1'b1, 2'b00, 1'b0, 64'h2005, 64'hAB);
        sb.push_back('{fault: 1'b0, rd: model_rd, lat: 5, req: 1'b1, be: 8'h20,
                       wdata: 64'h0000_AB00_0000_0000, addr: 64'h2000, we: 1'b1});
        service(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        pop_exp("st_byte");
        tests++;
        if (obs_be !== e.be || obs_wdata !== e.wdata || obs_we !== e.we || obs_addr !== e.addr) begin
            fails++;
            $display("FAIL st_byte_bus: be=%h wdata=%h we=%b addr=%h required %h %h %b %h", obs_be, obs_wdata, obs_we, obs_addr, e.be, e.wdata, e.we, e.addr);
        end
        tests++;
        if (obs_lat != e.lat || obs_fault !== e.fault || obs_rd !== e.rd) begin
            fails++;
            $display("FAIL st_byte: lat=%0d fault=%b rd=%h required %0d %b %h", obs_lat, obs_fault, obs_rd, e.lat, e.fault, e.rd);
        end
    endtask

    task automatic test_signed_word();
        logic [63:0] d = 64'h8000_0001_0000_0000;
        logic [63:0] req_rd[2];
        req_rd[0] = 64'hFFFF_FFFF_8000_0001;
        req_rd[1] = 64'h0000_0000_8000_0001;
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 1'b0, 2'b10, (k == 0), 64'h3004, '0);
            sb.push_back('{fault: 1'b0, rd: req_rd[k], lat: 2, req: 1'b1, be: 8'hF0,
                           wdata: '0, addr: 64'h3000, we: 1'b0});
            model_rd = req_rd[k];
            service(0, d, 1'b1);
            pop_exp("ld_word");
            tests++;
            if (obs_rd !== e.rd || obs_be !== e.be || obs_fault !== e.fault) begin
                fails++;
                $display("FAIL ld_word sx=%0d: rd=%h be=%h fault=%b required %h %h %b", (k == 0), obs_rd, obs_be, obs_fault, e.rd, e.be, e.fault);
            end
        end
    endtask

    task automatic test_faults();
        logic       rd_t[3];
        logic       wr_t[3];
        logic [1:0] sz_t[3];
        rd_t = '{1'b1, 1'b1, 1'b0};
        wr_t = '{1'b0, 1'b1, 1'b0};
        sz_t = '{2'b01, 2'b11, 2'b00};
        for (int k = 0; k < 3; k++) begin
            issue(rd_t[k], wr_t[k], sz_t[k], 1'b0, 64'h4001 + 64'(k) * 64'h10, 64'h55);
            sb.push_back('{fault: 1'b1, rd: model_rd, lat: 1, req: 1'b0, be: '0, wdata: '0, addr: '0, we: 1'b0});
            service(0, 64'h1234_5678_9ABC_DEF0, 1'b1);
            pop_exp("fault");
            tests++;
            if (obs_req !== e.req || obs_lat != e.lat || obs_fault !== e.fault || obs_rd !== e.rd) begin
                fails++;
                $display("FAIL fault case %0d: req=%b lat=%0d fault=%b rd=%h required %b %0d %b %h", k, obs_req, obs_lat, obs_fault, obs_rd, e.req, e.lat, e.fault, e.rd);
            end
        end
    endtask

    task automatic test_start_in_resp();
        issue(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, '0);
        @(negedge clk);
        tests++;
        if ({done, fault} !== 2'b11) begin
            fails++;
            $display("FAIL resp_setup: done/fault=%b required 11", {done, fault});
        end
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b11; address = 64'h5000;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, mem_req, done} !== 3'b000) begin
            fails++;
            $display("FAIL start_in_resp: busy/req/done=%b required 000", {busy, mem_req, done});
        end
        @(negedge clk);
        tests++;
        if ({busy, mem_req, done} !== 3'b000) begin
            fails++;
            $display("FAIL start_in_resp_after: busy/req/done=%b required 000", {busy, mem_req, done});
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h6000, '0);
        sb.push_back('{fault: 1'b1, rd: model_rd, lat: 5, req: 1'b1, be: 8'hFF, wdata: '0, addr: 64'h6000, we: 1'b0});
        service(1000, 64'h0, 1'b0);
        pop_exp("timeout");
        tests++;
        if (obs_reqcyc != 4 || obs_lat != e.lat || obs_fault !== e.fault || obs_rd !== e.rd) begin
            fails++;
            $display("FAIL timeout: reqcyc=%0d lat=%0d fault=%b rd=%h required 4 %0d %b %h", obs_reqcyc, obs_lat, obs_fault, obs_rd, e.lat, e.fault, e.rd);
        end
    endtask
`endif

    // Random legal accesses issued back to back with random wait states
    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            logic [1:0]  sz    = 2'($urandom_range(0, 3));
            logic        ld    = 1'($urandom_range(0, 1));
            logic        sx    = 1'($urandom_range(0, 1));
            logic [2:0]  off   = 3'($urandom_range(0, 7));
            logic [63:0] sd    = {$urandom, $urandom};
            logic [63:0] rdd   = {$urandom, $urandom};
            int          waits = $urandom_range(0, 3);
            logic [63:0] base  = {32'h0, 16'h0, 13'($urandom), 3'b000};
            off = (sz == 2'b00) ? off : (sz == 2'b01) ? {off[2:1], 1'b0} :
                  (sz == 2'b10) ? {off[2], 2'b00} : 3'b000;
            if (ld) model_rd = m_load(rdd, sz, off, sx);
            issue(ld, !ld, sz, sx, base | 64'(off), sd);
            sb.push_back('{fault: 1'b0, rd: model_rd, lat: 2 + waits, req: 1'b1, be: m_be(sz, off),
                           wdata: ld ? 64'h0 : m_wdata(sd, sz, off), addr: base, we: !ld});
            service(waits, rdd, 1'b1);
            pop_exp("b2b");
            tests++;
            if (obs_lat != e.lat || obs_fault !== e.fault || obs_rd !== e.rd || obs_be !== e.be ||
                obs_addr !== e.addr || obs_we !== e.we || (!ld && obs_wdata !== e.wdata)) begin
                fails++;
                $display("FAIL b2b #%0d: lat=%0d f=%b rd=%h be=%h addr=%h we=%b wd=%h required %0d %b %h %h %h %b %h",
                         n, obs_lat, obs_fault, obs_rd, obs_be, obs_addr, obs_we, obs_wdata,
                         e.lat, e.fault, e.rd, e.be, e.addr, e.we, e.wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_double();
        test_store_byte();
        test_signed_word();
        test_faults();
        test_start_in_resp();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
